// File: rtl/expande_chave_seq.sv
// AES-128 key expansion, one round key per cycle (two per cycle when
// EXPANDE_CHAVE_DUPLO_EN is defined); results held in chaveExpandida while pronto=1.
module expande_chave_seq (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inicio,
   input  logic [127:0]  chave,
   output logic [1279:0] chaveExpandida,
   output logic          pronto,
   output logic          ocupado
);

   typedef enum logic [1:0] {OCIOSO, EXPANDINDO, PRONTO} t_estado;

   localparam logic [2047:0] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

   t_estado        r_estado;
   t_estado        w_proxEstado;
   logic           w_proxPronto;
   logic           w_proxOcupado;
   logic           w_captura;
   logic           w_avanca;
   logic [127:0]   r_chaveTrab;
   logic [3:0]     r_rodada;
   logic [7:0]     r_rcon;
   logic [127:0]   w_chaveA;
   logic [127:0]   w_chaveFinal;
   logic [7:0]     w_rconProx;

   // Table byte 0 sits at the MSB end, so byte x starts at bit 8*(255-x) = {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] idx;
      idx = {~x, 3'b000};
      return SBOX_TBL[idx +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] proxChave(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w4, w5, w6, w7;
      t  = subWord({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
      w4 = k[127:96] ^ t;
      w5 = k[95:64]  ^ w4;
      w6 = k[63:32]  ^ w5;
      w7 = k[31:0]   ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   assign w_chaveA = proxChave(r_chaveTrab, r_rcon);

`ifdef EXPANDE_CHAVE_DUPLO_EN
   localparam logic [3:0] ULTIMA = 4'd8;
   localparam logic [3:0] PASSO  = 4'd2;
   logic [127:0] w_chaveB;
   assign w_chaveB     = proxChave(w_chaveA, xtime(r_rcon));
   assign w_chaveFinal = w_chaveB;
   assign w_rconProx   = xtime(xtime(r_rcon));
`else
   localparam logic [3:0] ULTIMA = 4'd9;
   localparam logic [3:0] PASSO  = 4'd1;
   assign w_chaveFinal = w_chaveA;
   assign w_rconProx   = xtime(r_rcon);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= OCIOSO;
         pronto   <= 1'b0;
         ocupado  <= 1'b0;
      end else begin
         r_estado <= w_proxEstado;
         pronto   <= w_proxPronto;
         ocupado  <= w_proxOcupado;
      end
   end

   // inicio is only honoured outside EXPANDINDO; a restart from PRONTO drops pronto at once.
   always_comb begin
      w_proxEstado  = r_estado;
      w_proxPronto  = pronto;
      w_proxOcupado = ocupado;
      w_captura     = 1'b0;
      w_avanca      = 1'b0;
      case (r_estado)
         OCIOSO, PRONTO: begin
            if (inicio) begin
               w_captura     = 1'b1;
               w_proxEstado  = EXPANDINDO;
               w_proxPronto  = 1'b0;
               w_proxOcupado = 1'b1;
            end
         end
         EXPANDINDO: begin
            w_avanca = 1'b1;
            if (r_rodada == ULTIMA) begin
               w_proxEstado  = PRONTO;
               w_proxPronto  = 1'b1;
               w_proxOcupado = 1'b0;
            end
         end
         default: begin
            w_proxEstado  = OCIOSO;
            w_proxPronto  = 1'b0;
            w_proxOcupado = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chaveExpandida <= '0;
         r_chaveTrab    <= '0;
         r_rodada       <= 4'd0;
         r_rcon         <= 8'h01;
      end else if (w_captura) begin
         r_chaveTrab <= chave;
         r_rodada    <= 4'd0;
         r_rcon      <= 8'h01;
      end else if (w_avanca) begin
         for (int i = 0; i < 10; i++) begin
`ifdef EXPANDE_CHAVE_DUPLO_EN
            if (r_rodada == 4'(i))
               chaveExpandida[128*i +: 128] <= w_chaveA;
            if (r_rodada + 4'd1 == 4'(i))
               chaveExpandida[128*i +: 128] <= w_chaveB;
`else
            if (r_rodada == 4'(i))
               chaveExpandida[128*i +: 128] <= w_chaveA;
`endif
         end
         r_chaveTrab <= w_chaveFinal;
         r_rodada    <= r_rodada + PASSO;
         r_rcon      <= w_rconProx;
      end
   end

endmodule

// File: doc/expande_chave_seq.md
EXPANDE_CHAVE_SEQ -- requirements
Module: expandeChaveSeq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by AES-128.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 inicio  input  1  start strobe, sampled on rising clk.
REQ-005 chave  input  128  cipher key, FIPS-197 word w0 = chave[127:96], w3 = chave[31:0].
REQ-006 chaveExpandida  output  1280  registered round keys; slice i = bits [128*i+127 : 128*i] holds round key i+1 (i = 0..9), in the same word order as chave.
REQ-007 pronto  output  1  registered level, high while chaveExpandida is complete and valid.
REQ-008 ocupado  output  1  registered level, high while expansion is in progress.

Function
REQ-009 The FSM SHALL have states OCIOSO, EXPANDINDO and PRONTO, encoded in a registered state variable.
REQ-010 In OCIOSO or PRONTO, inicio=1 SHALL capture chave into an internal working key, set the round counter to 0 and Rcon to 8'h01, clear pronto, set ocupado, and enter EXPANDINDO.
REQ-011 Each EXPANDINDO cycle SHALL compute the next round key from the working key using RotWord, SubWord (AES S-box) and Rcon XOR on w3, then the w4..w7 XOR chain, per FIPS-197.
REQ-012 On the same edge, the new key SHALL be written to slice = round counter and to the working key, and the counter SHALL increment.
REQ-013 Rcon SHALL follow 01,02,04,08,10,20,40,80,1b,36 (xtime with 0x1b reduction).
REQ-014 After the slice-9 write, the FSM SHALL enter PRONTO with pronto=1 and ocupado=0.
REQ-015 Latency: with inicio sampled at edge N, pronto SHALL first be high after edge N+10.
REQ-016 inicio SHALL be ignored while in EXPANDINDO.
REQ-017 Changes on chave after the capture edge SHALL NOT affect the expansion.
REQ-018 inicio in PRONTO SHALL restart immediately, with pronto dropping on that edge.
REQ-019 Slices not yet rewritten during a restart SHALL keep their previous values; consumers SHALL use chaveExpandida only while pronto=1.
REQ-020 pronto and ocupado SHALL never be high simultaneously.

Reset
REQ-021 With rst_n=0, the block SHALL immediately, independent of clk: enter OCIOSO, set chaveExpandida to 0, pronto to 0, ocupado to 0, the counter to 0, Rcon to 8'h01 and the working key to 0.
REQ-022 A reset asserted mid-expansion SHALL abort it; after release, the block SHALL wait in OCIOSO for inicio.
REQ-023 inicio SHALL NOT be accepted on the first rising edge that coincides with rst_n=0.

Configuration
REQ-024 Macro EXPANDE_CHAVE_DUPLO_EN, when defined, SHALL instantiate a second S-box and XOR-chain stage so that two round keys (slices 2k and 2k+1) are produced per EXPANDINDO cycle, giving a latency of 5 cycles (pronto after edge N+5) and Rcon advancing two steps per cycle.
REQ-025 When EXPANDE_CHAVE_DUPLO_EN is undefined, the block SHALL produce one round key per cycle with the 10-cycle latency of REQ-015.
REQ-026 Port list, reset behaviour and final chaveExpandida contents SHALL be identical in both builds.

Verification
REQ-027 Key 2b7e151628aed2a6abf7158809cf4f3c, inicio pulse -> after 10 edges pronto=1; slice 0 = a0fafe1788542cb123a339392a6c7605; slice 9 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-028 Key all-zero restarted from PRONTO -> pronto low on the start edge; after 10 edges slice 0 = 62636363626363636263636362636363 and slice 9 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 inicio re-pulsed and chave changed at cycle 4 of an expansion -> ignored; the REQ-027 result is unchanged and pronto occurs at N+10.
REQ-030 rst_n low at cycle 6 of an expansion -> outputs 0 immediately, state OCIOSO; a fresh inicio yields the correct REQ-027 result.
REQ-031 Build with EXPANDE_CHAVE_DUPLO_EN, REQ-027 stimulus -> pronto after edge N+5 with identical slice values; ocupado high for exactly 5 cycles.
